// File: rtl/pl_scrambler_pkg.sv
// pl_scr_pkg: shared constants, Gold-LFSR helpers and saturating negate for the PL scrambler
package pl_scr_pkg;
  localparam int HDR_LEN_DEF = 90;
  localparam logic [17:0] X_INIT_DEF = 18'h00001;
  localparam logic [17:0] Y_INIT_DEF = 18'h3FFFF;
  localparam logic [17:0] X_TAPS = 18'h00081;
  localparam logic [17:0] Y_TAPS = 18'h004A1;
  localparam logic [1:0] RN_0 = 2'd0;
  localparam logic [1:0] RN_1 = 2'd1;
  localparam logic [1:0] RN_2 = 2'd2;
  localparam logic [1:0] RN_3 = 2'd3;
  function automatic logic [17:0] lfsr_step(input logic [17:0] s, input logic [17:0] taps);
    return {^(s & taps), s[17:1]};
  endfunction
  // Jump ahead 2^17 steps: r = D^(2^17) mod p(D) by repeated squaring, then each
  // advanced state bit j is the inner product of D^(2^17+j) mod p with the start state.
  function automatic logic [17:0] lfsr_jump(input logic [17:0] s, input logic [17:0] taps);
    logic [35:0] t;
    logic [17:0] r;
    logic [17:0] q;
    r = 18'd2;
    for (int k = 0; k < 17; k++) begin
      t = '0;
      for (int b = 0; b < 18; b++) t[2*b] = r[b];
      for (int d = 35; d >= 18; d--)
        if (t[d]) t = t ^ ({18'd0, taps} << (d - 18)) ^ (36'd1 << d);
      r = t[17:0];
    end
    for (int j = 0; j < 18; j++) begin
      q[j] = ^(r & s);
      r = {r[16:0], 1'b0} ^ (r[17] ? taps : 18'd0);
    end
    return q;
  endfunction
  localparam logic [17:0] X_INIT_Q = lfsr_jump(X_INIT_DEF, X_TAPS);
  localparam logic [17:0] Y_INIT_Q = lfsr_jump(Y_INIT_DEF, Y_TAPS);
  function automatic logic signed [15:0] neg_sat(input logic signed [15:0] a);
    return (a == 16'sh8000) ? 16'sh7fff : -a;
  endfunction
endpackage

// File: rtl/pl_scrambler_if.sv
// pl_scrambler_if: symbol stream in/out of the PL scrambler
interface pl_scrambler_if;
  logic in_vld;
  logic in_sof;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  logic out_vld;
  logic out_sof;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  modport master(output in_vld, in_sof, in_re, in_im, input out_vld, out_sof, out_re, out_im);
  modport slave(input in_vld, in_sof, in_re, in_im, output out_vld, out_sof, out_re, out_im);
endinterface

// File: rtl/pl_scrambler_gold_lfsr18.sv
// gold_lfsr18: x/y 18-bit LFSR pair producing one Gold-sequence bit per step
module gold_lfsr18
  import pl_scr_pkg::*;
#(
  parameter logic [17:0] X_RST = X_INIT_DEF,
  parameter logic [17:0] Y_RST = Y_INIT_DEF
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [17:0] x_init,
  input  logic [17:0] y_init,
  output logic        z
);
  logic [17:0] x;
  logic [17:0] y;
  assign z = x[0] ^ y[0];
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      x <= X_RST;
      y <= Y_RST;
    end else if (load) begin
      x <= x_init;
      y <= y_init;
    end else if (step) begin
      x <= lfsr_step(x, X_TAPS);
      y <= lfsr_step(y, Y_TAPS);
    end
endmodule

// File: rtl/pl_scrambler.sv
// pl_scrambler: DVB-S2 PL scrambler, header symbols pass through, the rest rotated by j^Rn
module pl_scrambler
  import pl_scr_pkg::*;
#(
  parameter int          HDR_LEN = HDR_LEN_DEF,
  parameter logic [17:0] X_INIT  = X_INIT_DEF,
  parameter logic [17:0] Y_INIT  = Y_INIT_DEF
) (
  input logic           sys_clk,
  input logic           rst_n,
  input logic           fs_en,
  pl_scrambler_if.slave bus
);
  localparam logic [6:0] HDR_MAX = 7'(HDR_LEN);
  logic [6:0] hdr_cnt;
  logic sof;
  logic scr;
  logic zi;
  logic zq;
  logic [1:0] rn;
  logic signed [15:0] rot_re;
  logic signed [15:0] rot_im;
  assign sof = bus.in_vld & bus.in_sof;
  assign scr = bus.in_vld & ~bus.in_sof & (hdr_cnt == HDR_MAX);
  assign rn = {zq, zi};
  gold_lfsr18 #(.X_RST(X_INIT), .Y_RST(Y_INIT)) u_lfsr_i (
    .sys_clk, .rst_n, .load(fs_en & sof), .step(fs_en & scr),
    .x_init(X_INIT), .y_init(Y_INIT), .z(zi)
  );
  // Q pair runs 131072 steps ahead of the I pair
  gold_lfsr18 #(.X_RST(X_INIT_Q), .Y_RST(Y_INIT_Q)) u_lfsr_q (
    .sys_clk, .rst_n, .load(fs_en & sof), .step(fs_en & scr),
    .x_init(X_INIT_Q), .y_init(Y_INIT_Q), .z(zq)
  );
  always_comb begin
    rot_re = rn == RN_0 ? bus.in_re : rn == RN_1 ? neg_sat(bus.in_im) : rn == RN_2 ? neg_sat(bus.in_re) : bus.in_im;
    rot_im = rn == RN_0 ? bus.in_im : rn == RN_1 ? bus.in_re : rn == RN_2 ? neg_sat(bus.in_im) : neg_sat(bus.in_re);
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      hdr_cnt     <= '0;
      bus.out_vld <= 1'b0;
      bus.out_sof <= 1'b0;
      bus.out_re  <= '0;
      bus.out_im  <= '0;
    end else if (fs_en) begin
      hdr_cnt     <= sof ? 7'd1 : (bus.in_vld && hdr_cnt < HDR_MAX) ? hdr_cnt + 7'd1 : hdr_cnt;
      bus.out_vld <= bus.in_vld;
      bus.out_sof <= sof;
      bus.out_re  <= scr ? rot_re : bus.in_re;
      bus.out_im  <= scr ? rot_im : bus.in_im;
    end
endmodule

// File: tb/tb_pl_scrambler.sv
// tb_pl_scrambler: randomized self-checking bench against a Gold-sequence reference model
module tb_pl_scrambler;
  localparam int N = 131072 + 4096;
  logic sys_clk = 1'b0;
  logic rst_n;
  logic fs_en;
  pl_scrambler_if bus ();
  pl_scrambler dut (.sys_clk(sys_clk), .rst_n(rst_n), .fs_en(fs_en), .bus(bus));
  always #5 sys_clk = ~sys_clk;

  bit xs[N];
  bit ys[N];
  logic [1:0] rn_tab[4096];
  logic [31:0] rot_1k[4];
  logic [31:0] rot_min[4];
  int n_vec = 0;
  int n_bad = 0;
  int nsym;
  int kpay;
  int last_r;
  logic [33:0] exp_out;
  logic [17:0] xq_exp;
  logic [17:0] yq_exp;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  // One clock: drive inputs, predict the registered output, compare after the edge
  task automatic cycle(input logic en, input logic vld, input logic sof,
                       input logic signed [15:0] re, input logic signed [15:0] im, input string tag);
    int r, i, q, t;
    fs_en = en;
    bus.in_vld = vld;
    bus.in_sof = sof;
    bus.in_re = re;
    bus.in_im = im;
    if (en) begin
      r = 0;
      i = re;
      q = im;
      if (vld && sof) begin
        nsym = 1;
        kpay = 0;
      end else if (vld) begin
        nsym++;
        if (nsym > 90) begin
          r = int'(rn_tab[kpay]);
          kpay++;
        end
      end
      repeat (r) begin
        t = i;
        i = -q;
        q = t;
      end
      last_r = r;
      exp_out = {vld, vld & sof, 16'(sat(i)), 16'(sat(q))};
    end
    @(posedge sys_clk);
    #1;
    check(tag, {2'd0, bus.out_vld, bus.out_sof, bus.out_re, bus.out_im}, {2'd0, exp_out});
  endtask

  // One valid symbol, optionally preceded by bubbles and fs_en-low hold cycles
  task automatic sym(input logic sof, input logic signed [15:0] re, input logic signed [15:0] im,
                     input bit gap, input string tag);
    if (gap) begin
      while ($urandom_range(3) == 0)
        cycle(1'($urandom_range(1)), 1'b0, 1'b0, 16'($urandom), 16'($urandom), "bubble");
      while ($urandom_range(1) == 0)
        cycle(1'b0, 1'b1, sof, re, im, "hold");
    end
    cycle(1'b1, 1'b1, sof, re, im, tag);
  endtask

  task automatic out_pair(input string tag, input logic [31:0] exp);
    check(tag, {4'd0, bus.out_re, bus.out_im}, {4'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 18; i++) begin
      xs[i] = (i == 0);
      ys[i] = 1'b1;
    end
    for (int i = 0; i < N - 18; i++) begin
      xs[i+18] = xs[i+7] ^ xs[i];
      ys[i+18] = ys[i+10] ^ ys[i+7] ^ ys[i+5] ^ ys[i];
    end
    for (int k = 0; k < 4096; k++)
      rn_tab[k] = {xs[k+131072] ^ ys[k+131072], xs[k] ^ ys[k]};
    for (int j = 0; j < 18; j++) begin
      xq_exp[j] = xs[131072+j];
      yq_exp[j] = ys[131072+j];
    end
    rot_1k = '{32'h03E8_07D0, 32'hF830_03E8, 32'hFC18_F830, 32'h07D0_FC18};
    rot_min = '{32'h8000_8000, 32'h7FFF_8000, 32'h7FFF_7FFF, 32'h8000_7FFF};
    rst_n = 1'b0;
    fs_en = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    nsym = 0;
    kpay = 0;
    last_r = 0;
    exp_out = '0;
    #12;
    check("reset_out", {2'd0, bus.out_vld, bus.out_sof, bus.out_re, bus.out_im}, 36'd0);
    check("reset_lfsr_i", {dut.u_lfsr_i.x, dut.u_lfsr_i.y}, {18'h00001, 18'h3FFFF});
    check("reset_lfsr_q", {dut.u_lfsr_q.x, dut.u_lfsr_q.y}, {xq_exp, yq_exp});
    #2 rst_n = 1'b1;
    // Frame A: fixed header, then 1000 payload symbols of (1000, 2000), gap-free
    sym(1'b1, 16'sh0b50, 16'shf4b0, 1'b0, "hdr_a");
    for (int i = 1; i < 90; i++) sym(1'b0, 16'sh0b50, 16'shf4b0, 1'b0, "hdr_a");
    check("hdr_lfsr_hold", {dut.u_lfsr_i.x, dut.u_lfsr_i.y}, {18'h00001, 18'h3FFFF});
    for (int k = 0; k < 1000; k++) begin
      sym(1'b0, 16'sd1000, 16'sd2000, 1'b0, "pay_a");
      out_pair(k == 0 ? "pay_a_first" : "pay_a_rot", rot_1k[rn_tab[k]]);
    end
    // Frame B: gaps, random header data, periodic -32768 symbols
    sym(1'b1, 16'($urandom), 16'($urandom), 1'b1, "hdr_b");
    for (int i = 1; i < 90; i++) sym(1'b0, 16'($urandom), 16'($urandom), 1'b1, "hdr_b");
    for (int k = 0; k < 500; k++) begin
      if (k % 7 == 3) begin
        sym(1'b0, 16'sh8000, 16'sh8000, 1'b1, "pay_b_sat");
        out_pair("sat_neg", rot_min[rn_tab[k]]);
      end else begin
        sym(1'b0, 16'sd1000, 16'sd2000, 1'b1, "pay_b");
        out_pair("gap_vs_gapfree", rot_1k[rn_tab[k]]);
      end
    end
    // Frame C: restart after 500 payload symbols, Rn sequence begins again
    sym(1'b1, 16'($urandom), 16'($urandom), 1'b0, "hdr_c");
    for (int i = 1; i < 90; i++) sym(1'b0, 16'($urandom), 16'($urandom), 1'b0, "hdr_c");
    for (int k = 0; k < 200; k++) begin
      sym(1'b0, 16'sd1000, 16'sd2000, 1'b0, "pay_c");
      out_pair("restart_rn", rot_1k[rn_tab[k]]);
    end
    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    nsym = 0;
    kpay = 0;
    exp_out = '0;
    #1;
    check("async_rst_out", {2'd0, bus.out_vld, bus.out_sof, bus.out_re, bus.out_im}, 36'd0);
    check("async_rst_lfsr", {dut.u_lfsr_i.x, dut.u_lfsr_i.y}, {18'h00001, 18'h3FFFF});
    @(posedge sys_clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic signed [15:0] re, im;
      re = 16'($urandom);
      im = 16'($urandom);
      sym(1'b0, re, im, 1'b1, "post_rst");
      out_pair("post_rst_unrot", {re, im});
    end
    // Frame D: random data with gaps after reset
    sym(1'b1, 16'($urandom), 16'($urandom), 1'b1, "hdr_d");
    for (int i = 1; i < 90; i++) sym(1'b0, 16'($urandom), 16'($urandom), 1'b1, "hdr_d");
    for (int k = 0; k < 300; k++) sym(1'b0, 16'($urandom), 16'($urandom), 1'b1, "pay_d");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
